uart_tx_param: RTL and testbench

- Parametrised successor to the fixed 8N1 UART transmitter used by the GPSDO status/telemetry path.
- Configurable frame: data bits, parity mode and stop bits.
- Adds a transmit FIFO with a valid/ready write interface, so firmware and logic producers can queue bytes without polling a busy flag.
- Every bit, including the stop bit(s), is exactly one full bit period long.

---
 rtl/uart_tx_param.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a valid/ready transmit FIFO.
// Define UART_TX_BREAK_EN to add Tx_break, which holds the line low while idle.
module uart_tx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                 CLK_SYS,
    input  logic                 CLK_RST,
    input  logic [DATA_BITS-1:0] Tx_data,
    input  logic                 Tx_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                 Tx_break,
`endif
    output logic                 Tx_ready,
    output logic [AW:0]          Fifo_level,
    output logic                 Uart_TX_busy,
    output logic                 Uart_TXD
);
    localparam logic [15:0] BPS_CNT = 16'(CLK_FREQ / UART_BPS);
    localparam logic PAR_INV = PARITY == 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_level;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [3:0]           r_bit_cnt;
    logic [15:0]          r_baud;
    logic                 r_txd;
    logic                 r_busy;
`ifdef UART_TX_BREAK_EN
    logic                 r_mark;
`endif
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_last_stop;
    logic                 w_idle_go;
    logic [DATA_BITS-1:0] w_head;

    assign w_full      = r_level == (AW+1)'(FIFO_DEPTH);
    assign w_empty     = r_level == '0;
    assign w_wr        = Tx_valid && !w_full;
    assign w_bit_end   = r_baud == BPS_CNT - 16'd1;
    assign w_last_stop = r_state == STOP && w_bit_end && r_bit_cnt == 4'(STOP_BITS - 1);
`ifdef UART_TX_BREAK_EN
    assign w_idle_go   = r_state == IDLE && !Tx_break && !r_mark;
`else
    assign w_idle_go   = r_state == IDLE;
`endif
    // A pop launches a frame: either from idle or straight out of the final stop bit.
    assign w_pop       = !w_empty && (w_idle_go || w_last_stop);
    assign w_head      = r_mem[r_rd_ptr];

    assign Tx_ready     = !w_full;
    assign Fifo_level   = r_level;
    assign Uart_TX_busy = r_busy;
    assign Uart_TXD     = r_txd;

    always_ff @(posedge CLK_SYS) begin
        if (w_wr) r_mem[r_wr_ptr] <= Tx_data;
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_bit_cnt <= '0;
            r_baud    <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            r_mark    <= 1'b0;
`endif
        end else begin
            r_baud <= (r_state == IDLE || w_bit_end) ? '0 : r_baud + 16'd1;
            if (w_pop) begin
                r_shift <= w_head;
                r_par   <= ^w_head ^ PAR_INV;
                r_state <= START;
                r_txd   <= 1'b0;
                r_busy  <= 1'b1;
                r_baud  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
`ifdef UART_TX_BREAK_EN
                        // After a break, one full mark period is timed before the next pop.
                        r_txd  <= !Tx_break;
                        r_busy <= Tx_break || r_mark;
                        if (Tx_break) begin
                            r_mark <= 1'b1;
                        end else if (r_mark) begin
                            r_baud <= w_bit_end ? '0 : r_baud + 16'd1;
                            r_mark <= !w_bit_end;
                        end
`else
                        r_txd  <= 1'b1;
                        r_busy <= 1'b0;
`endif
                    end
                    START: begin
                        if (w_bit_end) begin
                            r_state   <= DATA;
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (w_bit_end) begin
                            if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
                                r_bit_cnt <= '0;
                                r_state   <= (PARITY != 0) ? PAR : STOP;
                                r_txd     <= (PARITY != 0) ? r_par : 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                                r_txd     <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                            end
                        end
                    end
                    PAR: begin
                        if (w_bit_end) begin
                            r_state <= STOP;
                            r_txd   <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (w_bit_end) begin
                            if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench driving 8N1 (depth 4), 8E2 and 8O1 builds of uart_tx_param.
module tb_uart_tx_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] valid = '0;
    logic [2:0] en = '1;
    logic [2:0] txd;
    logic [2:0] rdy;
    logic [2:0] busy;
    logic [7:0] din [3];
    logic [2:0] lvl0;
    logic [4:0] lvl1;
    logic [4:0] lvl2;
`ifdef UART_TX_BREAK_EN
    logic       brk = 1'b0;
`endif
    int cyc = 0;
    int checks = 0;
    int errs = 0;
    int nb [3];

    typedef struct {
        int         ch;
        logic [7:0] d;
        int         w;
    } ent_t;
    ent_t q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
        .CLK_SYS(clk), .CLK_RST(rst_n), .Tx_data(din[0]), .Tx_valid(valid[0]),
`ifdef UART_TX_BREAK_EN
        .Tx_break(brk),
`endif
        .Tx_ready(rdy[0]), .Fifo_level(lvl0), .Uart_TX_busy(busy[0]), .Uart_TXD(txd[0]));

    uart_tx_param #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_e2 (
        .CLK_SYS(clk), .CLK_RST(rst_n), .Tx_data(din[1]), .Tx_valid(valid[1]),
`ifdef UART_TX_BREAK_EN
        .Tx_break(1'b0),
`endif
        .Tx_ready(rdy[1]), .Fifo_level(lvl1), .Uart_TX_busy(busy[1]), .Uart_TXD(txd[1]));

    uart_tx_param #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_o1 (
        .CLK_SYS(clk), .CLK_RST(rst_n), .Tx_data(din[2]), .Tx_valid(valid[2]),
`ifdef UART_TX_BREAK_EN
        .Tx_break(1'b0),
`endif
        .Tx_ready(rdy[2]), .Fifo_level(lvl2), .Uart_TX_busy(busy[2]), .Uart_TXD(txd[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int k, input logic [7:0] d, output int w);
        ent_t e;
        din[k] = d;
        valid[k] = 1'b1;
        chk($sformatf("ready ch%0d", k), rdy[k], 1);
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
        w = cyc;
        e.ch = k;
        e.d = d;
        e.w = w;
        q.push_back(e);
    endtask

    // Wire order: start, data LSB first, optional parity, then stop ones.
    function automatic logic [11:0] frame(input logic [7:0] d, input int p);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (p != 0) f[9] = (^d) ^ (p == 1);
        return f;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_mon
        localparam int P = (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int SB = (g == 1) ? 2 : 1;
        localparam int NBITS = 9 + ((P != 0) ? 1 : 0) + SB;
        initial begin
            ent_t e;
            logic [11:0] fb;
            int s;
            int bad;
            int exp_s;
            bit ab;
            bit found;
            nb[g] = 0;
            forever begin
                @(negedge clk);
                if (en[g] && rst_n && txd[g] === 1'b0) begin
                    s = cyc;
                    found = 0;
                    ab = 0;
                    for (int i = 0; i < q.size(); i++) begin
                        if (!found && q[i].ch == g) begin
                            e = q[i];
                            q.delete(i);
                            found = 1;
                        end
                    end
                    if (!found) begin
                        checks++;
                        errs++;
                        $display("FAIL ch%0d unexpected frame: start at cycle %0d, none required", g, s);
                    end else begin
                        exp_s = (nb[g] > e.w + 1) ? nb[g] : e.w + 1;
                        chk($sformatf("ch%0d start cycle of %02h", g, e.d), s, exp_s);
                        fb = frame(e.d, P);
                        for (int b = 0; b < NBITS && !ab; b++) begin
                            bad = 0;
                            for (int c = 0; c < 10 && !ab; c++) begin
                                if (b != 0 || c != 0) @(negedge clk);
                                if (!rst_n) ab = 1;
                                else if (txd[g] !== fb[b]) bad++;
                            end
                            if (!ab) chk($sformatf("ch%0d frame %02h bit %0d bad cycles", g, e.d, b), bad, 0);
                        end
                        nb[g] = ab ? 0 : s + NBITS * 10;
                    end
                end
            end
        end
    end

    initial begin
        int w;
        int w0;
        int bad;
        din[0] = '0;
        din[1] = '0;
        din[2] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset txd", txd, 3'b111);
        chk("reset ready", rdy, 3'b111);
        chk("reset busy", busy, 3'b000);
        chk("reset level ch0", lvl0, 0);
        chk("reset level ch1", lvl1, 0);
        chk("reset level ch2", lvl2, 0);
        rst_n = 1'b1;
        to(cyc + 2);

        // 8N1 single frame of 0xA5
        wr(0, 8'hA5, w);
        chk("8N1 busy at write", busy[0], 0);
        chk("8N1 level at write", lvl0, 1);
        to(w + 1);
        chk("8N1 busy at start", busy[0], 1);
        chk("8N1 txd at start", txd[0], 0);
        chk("8N1 level after pop", lvl0, 0);
        to(w + 100);
        chk("8N1 busy in stop", busy[0], 1);
        to(w + 101);
        chk("8N1 busy after frame", busy[0], 0);

        // 8E2 frame of 0x07
        wr(1, 8'h07, w);
        to(w + 96);
        chk("8E2 parity bit", txd[1], 1);
        to(w + 120);
        chk("8E2 second stop", txd[1], 1);
        chk("8E2 busy last cycle", busy[1], 1);
        to(w + 121);
        chk("8E2 busy after frame", busy[1], 0);

        // 8O1 frame of 0x07 followed by three queued words
        wr(2, 8'h07, w);
        to(w + 5);
        wr(2, 8'h55, w0);
        chk("b2b level 1", lvl2, 1);
        wr(2, 8'hAA, w0);
        chk("b2b level 2", lvl2, 2);
        wr(2, 8'h0F, w0);
        chk("b2b level 3", lvl2, 3);
        to(w + 96);
        chk("8O1 parity bit", txd[2], 0);
        to(w + 110);
        chk("b2b level before pop", lvl2, 3);
        to(w + 111);
        chk("b2b level pop 1", lvl2, 2);
        chk("b2b no gap", txd[2], 0);
        to(w + 221);
        chk("b2b level pop 2", lvl2, 1);
        to(w + 331);
        chk("b2b level pop 3", lvl2, 0);
        to(w + 440);
        chk("b2b busy last cycle", busy[2], 1);
        to(w + 441);
        chk("b2b busy after", busy[2], 0);

        // Full FIFO on the depth-4 build
        to(cyc + 3);
        w0 = 0;
        for (int i = 0; i < 10; i++) begin
            ent_t e;
            din[0] = 8'(16 + i);
            valid[0] = 1'b1;
            chk($sformatf("full ready step %0d", i), rdy[0], i < 5);
            @(posedge clk);
            #1;
            if (i == 0) w0 = cyc;
            if (i < 5) begin
                e.ch = 0;
                e.d = 8'(16 + i);
                e.w = cyc;
                q.push_back(e);
            end
        end
        valid[0] = 1'b0;
        chk("full level", lvl0, 4);
        to(w0 + 500);
        chk("full busy last cycle", busy[0], 1);
        to(w0 + 501);
        chk("full busy after", busy[0], 0);

        // Reset during data bit 3, with one more word queued
        to(cyc + 3);
        wr(0, 8'h99, w);
        wr(0, 8'h66, w0);
        to(w + 46);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort txd", txd[0], 1);
        chk("abort level", lvl0, 0);
        chk("abort busy", busy[0], 0);
        chk("abort ready", rdy[0], 1);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        to(cyc + 2);
        wr(0, 8'h3C, w);
        to(w + 101);
        chk("after reset busy", busy[0], 0);

`ifdef UART_TX_BREAK_EN
        // Break while idle with 0x01 queued: 50 low, 10 mark, then the frame
        to(cyc + 3);
        en[0] = 1'b0;
        brk = 1'b1;
        wr(0, 8'h01, w);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            to(w + i);
            if (txd[0] !== 1'b0) bad++;
        end
        chk("break busy", busy[0], 1);
        brk = 1'b0;
        chk("break low cycles bad", bad, 0);
        bad = 0;
        for (int i = 50; i < 60; i++) begin
            to(w + i);
            if (txd[0] !== 1'b1) bad++;
        end
        chk("break mark cycles bad", bad, 0);
        nb[0] = w + 60;
        en[0] = 1'b1;
        to(w + 60);
        chk("break frame start", txd[0], 0);
        to(w + 161);
        chk("break busy after", busy[0], 0);
`endif

        to(cyc + 5);
        chk("scoreboard drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
